mm_bus_initiator: RTL

- Initiator end of the memory-mapped peripheral bus: sits between the core load/store unit and the peripheral bus that GPIO and other MMIO peripherals respond on.
- Accepts one request at a time from the core over a valid/ready handshake and drives the bus address, write data and write/read asserts.
- Waits for the peripheral's WriteOK/ReadOK, captures read data and returns a single response with an error flag.
- A bounded wait timeout keeps a dead or unmapped peripheral from hanging the core.

---
 rtl/mm_bus_initiator_pkg.sv | 21 ++
 rtl/mm_bus_initiator_if.sv | 41 ++++
 rtl/mm_bus_initiator.sv | 103 ++++++++++
 3 files changed

// File: rtl/mm_bus_initiator_pkg.sv
// Shared definitions for the memory-mapped peripheral bus initiator.
//   state_t        : initiator FSM states
//   ADDR_W_DEF     : default address width
//   DATA_W_DEF     : default data width
//   RESP_OK/RESP_TIMEOUT : values of the response error flag
package mm_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  localparam logic RESP_OK      = 1'b0;
  localparam logic RESP_TIMEOUT = 1'b1;

endpackage

// File: rtl/mm_bus_initiator_if.sv
// Core-side request/response handshake plus peripheral-side bus signals.
//   Req*        : core request (valid/ready, write flag, address, write data)
//   Resp*       : single response back to the core (data, timeout error)
//   AddressBus/DataWriteBus/WriteAssert/ReadAssert : driven onto the bus
//   DataReadBus/WriteOK/ReadOK : returned by the addressed peripheral
// master = initiator view, slave = view of the core + peripheral side.
interface mm_bus_initiator_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  logic              ReqValid;
  logic              ReqReady;
  logic              ReqWrite;
  logic [ADDR_W-1:0] ReqAddr;
  logic [DATA_W-1:0] ReqWData;
  logic              RespValid;
  logic              RespReady;
  logic [DATA_W-1:0] RespRData;
  logic              RespError;
  logic [ADDR_W-1:0] AddressBus;
  logic [DATA_W-1:0] DataWriteBus;
  logic              WriteAssert;
  logic              ReadAssert;
  logic [DATA_W-1:0] DataReadBus;
  logic              WriteOK;
  logic              ReadOK;

  modport master (
    input  ReqValid, ReqWrite, ReqAddr, ReqWData, RespReady,
           DataReadBus, WriteOK, ReadOK,
    output ReqReady, RespValid, RespRData, RespError,
           AddressBus, DataWriteBus, WriteAssert, ReadAssert
  );

  modport slave (
    output ReqValid, ReqWrite, ReqAddr, ReqWData, RespReady,
           DataReadBus, WriteOK, ReadOK,
    input  ReqReady, RespValid, RespRData, RespError,
           AddressBus, DataWriteBus, WriteAssert, ReadAssert
  );
endinterface

// File: rtl/mm_bus_initiator.sv
// Initiator end of the memory-mapped peripheral bus. Takes one core request
// at a time, strobes it onto the bus, waits for WriteOK/ReadOK (bounded by
// TIMEOUT_CYCLES, 0 = wait forever) and returns one response.
// Ports:
//   CoreClock : clock, all state on rising edge
//   Reset_n   : asynchronous active-low reset
//   bus       : mm_bus_initiator_if.master (core handshake + peripheral bus)
module mm_bus_initiator
  import mm_bus_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               CoreClock,
  input  logic               Reset_n,
  mm_bus_initiator_if.master bus
);

  // Counter width is sized for TIMEOUT_CYCLES; keep at least 1 bit when disabled.
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES : 1);

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic              ok;
  logic              timeout_hit;

  // OK only counts in the matching bus state; stray OKs are ignored.
  assign ok = ((state == WRITE) && bus.WriteOK) || ((state == READ) && bus.ReadOK);
  // Fires on the edge that closes the TIMEOUT_CYCLES-th strobe cycle.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST);

  // State register
  always_ff @(posedge CoreClock or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_n;
  end

  // Next state; OK takes priority over a simultaneous timeout.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:        if (bus.ReqValid) state_n = bus.ReqWrite ? WRITE : READ;
      WRITE, READ: if (ok || timeout_hit) state_n = RESP;
      RESP:        if (bus.RespReady) state_n = IDLE;
      default:     state_n = IDLE;
    endcase
  end

  // Request latch, response capture and saturating wait counter.
  always_ff @(posedge CoreClock or negedge Reset_n) begin
    if (!Reset_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= RESP_OK;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: if (bus.ReqValid) begin
          addr_q  <= bus.ReqAddr;
          wdata_q <= bus.ReqWData;
          rdata_q <= '0;
          err_q   <= RESP_OK;
          cnt     <= '0;
        end
        WRITE, READ: begin
          if (ok) begin
            rdata_q <= (state == READ) ? bus.DataReadBus : '0;
            err_q   <= RESP_OK;
          end else begin
            if (timeout_hit) begin
              rdata_q <= '0;
              err_q   <= RESP_TIMEOUT;
            end
            if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs: strobes decode straight from state so reset kills them at once.
  // Address/data hold their last values outside the bus states.
  always_comb begin
    bus.ReqReady     = (state == IDLE);
    bus.WriteAssert  = (state == WRITE);
    bus.ReadAssert   = (state == READ);
    bus.RespValid    = (state == RESP);
    bus.RespRData    = rdata_q;
    bus.RespError    = err_q;
    bus.AddressBus   = addr_q;
    bus.DataWriteBus = wdata_q;
  end

endmodule
